// File: rtl/rr_lzc_scheduler_pkg.sv
// Shared types and default sizing for the round-robin leading-one scheduler.
package rr_lzc_scheduler_pkg;

    localparam int unsigned DefNumReq   = 8;
    localparam int unsigned DefCntWidth = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_e;

endpackage

// File: rtl/fp_leading_one.sv
// MSB-first leading-one detector: first_one_o is the distance of the first set bit from the MSB.
module fp_leading_one #(
    parameter int unsigned LEN = 8
) (
    input  logic [LEN-1:0]         in_i,
    output logic [$clog2(LEN)-1:0] first_one_o,
    output logic                   no_ones_o
);

    localparam int unsigned PosWidth = $clog2(LEN);

    always_comb begin
        first_one_o = '0;
        no_ones_o   = 1'b1;
        for (int unsigned i = 0; i < LEN; i++) begin
            if (no_ones_o && in_i[LEN-1-i]) begin
                first_one_o = PosWidth'(i);
                no_ones_o   = 1'b0;
            end
        end
    end

endmodule

// File: rtl/rr_lzc_scheduler.sv
// Round-robin grant scheduler: highest index wins, with priority rotating below the last handshaken index.
module rr_lzc_scheduler
    import rr_lzc_scheduler_pkg::*;
#(
    parameter int unsigned NumReq   = DefNumReq,
    parameter int unsigned CntWidth = DefCntWidth
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NumReq-1:0]         req_i,
    input  logic                      ready_i,
    output logic                      valid_o,
    output logic [NumReq-1:0]         gnt_o,
    output logic [$clog2(NumReq)-1:0] gnt_idx_o,
    output logic [CntWidth-1:0]       gnt_cnt_o
);

    localparam int unsigned IdxWidth = $clog2(NumReq);

    state_e                state_q, state_d;
    logic [NumReq-1:0]     gnt_q, gnt_d;
    logic [IdxWidth-1:0]   idx_q, idx_d;
    logic [IdxWidth-1:0]   last_q, last_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;

    logic [NumReq-1:0]     arb_req;
    logic [NumReq-1:0]     masked_req;
    logic [IdxWidth-1:0]   arb_last;
    logic [IdxWidth-1:0]   masked_first;
    logic [IdxWidth-1:0]   unmasked_first;
    logic                  masked_none;
    logic                  unmasked_none;
    logic [IdxWidth-1:0]   win_first;
    logic [IdxWidth-1:0]   win_idx;

    // While offering, arbitration anticipates a handshake: current grant removed, pointer at it.
    always_comb begin
        arb_req    = req_i & ~gnt_q;
        arb_last   = (state_q == OFFER) ? idx_q : last_q;
        masked_req = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            if (i < 32'(arb_last)) begin
                masked_req[i] = arb_req[i];
            end
        end
    end

    fp_leading_one #(
        .LEN (NumReq)
    ) u_lzc_masked (
        .in_i        (masked_req),
        .first_one_o (masked_first),
        .no_ones_o   (masked_none)
    );

    fp_leading_one #(
        .LEN (NumReq)
    ) u_lzc_unmasked (
        .in_i        (arb_req),
        .first_one_o (unmasked_first),
        .no_ones_o   (unmasked_none)
    );

    always_comb begin
        win_first = masked_none ? unmasked_first : masked_first;
        win_idx   = IdxWidth'(NumReq - 1) - win_first;
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (!unmasked_none) begin
                    state_d = OFFER;
                    gnt_d   = NumReq'(1) << win_idx;
                    idx_d   = win_idx;
                end
            end
            OFFER: begin
                if (ready_i) begin
                    cnt_d  = cnt_q + CntWidth'(1);
                    last_d = idx_q;
                    if (!unmasked_none) begin
                        gnt_d = NumReq'(1) << win_idx;
                        idx_d = win_idx;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        idx_d   = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            last_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign valid_o   = (state_q == OFFER);
    assign gnt_o     = gnt_q;
    assign gnt_idx_o = idx_q;
    assign gnt_cnt_o = cnt_q;

endmodule

// File: tb/tb_rr_lzc_scheduler.sv
// Directed bench for rr_lzc_scheduler; a second instance with a 4-bit counter covers wrap-around.
module tb_rr_lzc_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  req;
    logic        ready;

    logic        valid;
    logic [7:0]  gnt;
    logic [2:0]  idx;
    logic [15:0] cnt;

    logic        valid4;
    logic [7:0]  gnt4;
    logic [2:0]  idx4;
    logic [3:0]  cnt4;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    rr_lzc_scheduler #(.NumReq(8), .CntWidth(16)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .req_i     (req),
        .ready_i   (ready),
        .valid_o   (valid),
        .gnt_o     (gnt),
        .gnt_idx_o (idx),
        .gnt_cnt_o (cnt)
    );

    rr_lzc_scheduler #(.NumReq(8), .CntWidth(4)) dut4 (
        .clk_i     (clk),
        .rst_i     (rst),
        .req_i     (req),
        .ready_i   (ready),
        .valid_o   (valid4),
        .gnt_o     (gnt4),
        .gnt_idx_o (idx4),
        .gnt_cnt_o (cnt4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst   = 1'b1;
        req   = 8'h00;
        ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            tick();
            n_chk++;
            if ({valid, gnt, idx, cnt} !== {1'b0, 8'h00, 3'd0, 16'd0}) begin
                $display("FAIL reset_idle cyc%0d: got v=%b g=%h i=%0d c=%0d, exp v=0 g=00 i=0 c=0",
                         i, valid, gnt, idx, cnt);
            end else n_pass++;
        end
    endtask

    task automatic test_rr_pair();
        logic [2:0] exp_idx [4];
        logic [7:0] exp_gnt;
        exp_idx = '{3'd5, 3'd0, 3'd5, 3'd0};
        apply_reset();
        req   = 8'h21;
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_gnt = 8'h01 << exp_idx[i];
            n_chk++;
            if ({valid, gnt, idx, cnt} !== {1'b1, exp_gnt, exp_idx[i], 16'(i)}) begin
                $display("FAIL rr_pair step%0d: got v=%b g=%h i=%0d c=%0d, exp v=1 g=%h i=%0d c=%0d",
                         i, valid, gnt, idx, cnt, exp_gnt, exp_idx[i], i);
            end else n_pass++;
        end
        req = 8'h00;
        tick();
        n_chk++;
        if ({valid, gnt, idx, cnt} !== {1'b0, 8'h00, 3'd0, 16'd4}) begin
            $display("FAIL rr_pair_drain: got v=%b g=%h i=%0d c=%0d, exp v=0 g=00 i=0 c=4",
                     valid, gnt, idx, cnt);
        end else n_pass++;
        ready = 1'b0;
    endtask

    task automatic test_hold();
        apply_reset();
        req   = 8'h81;
        ready = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            if (i == 2) req = 8'h01;
            tick();
            n_chk++;
            if ({valid, gnt, idx, cnt} !== {1'b1, 8'h80, 3'd7, 16'd0}) begin
                $display("FAIL hold cyc%0d: got v=%b g=%h i=%0d c=%0d, exp v=1 g=80 i=7 c=0",
                         i, valid, gnt, idx, cnt);
            end else n_pass++;
        end
        ready = 1'b1;
        tick();
        n_chk++;
        if ({valid, gnt, idx, cnt} !== {1'b1, 8'h01, 3'd0, 16'd1}) begin
            $display("FAIL hold_release: got v=%b g=%h i=%0d c=%0d, exp v=1 g=01 i=0 c=1",
                     valid, gnt, idx, cnt);
        end else n_pass++;
        tick();
        n_chk++;
        if ({valid, gnt, idx, cnt} !== {1'b0, 8'h00, 3'd0, 16'd2}) begin
            $display("FAIL hold_drain: got v=%b g=%h i=%0d c=%0d, exp v=0 g=00 i=0 c=2",
                     valid, gnt, idx, cnt);
        end else n_pass++;
        req   = 8'h00;
        ready = 1'b0;
    endtask

    task automatic test_single();
        apply_reset();
        req   = 8'h04;
        ready = 1'b1;
        tick();
        n_chk++;
        if ({valid, gnt, idx, cnt} !== {1'b1, 8'h04, 3'd2, 16'd0}) begin
            $display("FAIL single_offer: got v=%b g=%h i=%0d c=%0d, exp v=1 g=04 i=2 c=0",
                     valid, gnt, idx, cnt);
        end else n_pass++;
        req = 8'h00;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_chk++;
            if ({valid, gnt, idx, cnt} !== {1'b0, 8'h00, 3'd0, 16'd1}) begin
                $display("FAIL single_idle cyc%0d: got v=%b g=%h i=%0d c=%0d, exp v=0 g=00 i=0 c=1",
                         i, valid, gnt, idx, cnt);
            end else n_pass++;
        end
        ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp_idx [5];
        logic [7:0] exp_gnt;
        exp_idx = '{3'd7, 3'd5, 3'd2, 3'd1, 3'd7};
        apply_reset();
        req   = 8'hA6;
        ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            exp_gnt = 8'h01 << exp_idx[i];
            n_chk++;
            if ({valid, gnt, idx, cnt} !== {1'b1, exp_gnt, exp_idx[i], 16'(i)}) begin
                $display("FAIL back_to_back step%0d: got v=%b g=%h i=%0d c=%0d, exp v=1 g=%h i=%0d c=%0d",
                         i, valid, gnt, idx, cnt, exp_gnt, exp_idx[i], i);
            end else n_pass++;
        end
        req   = 8'h00;
        ready = 1'b0;
    endtask

    task automatic test_reset_priority();
        logic [2:0] exp_idx [3];
        exp_idx = '{3'd7, 3'd6, 3'd5};
        apply_reset();
        req   = 8'hFF;
        ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_chk++;
            if ({valid, idx, cnt} !== {1'b1, exp_idx[i], 16'(i)}) begin
                $display("FAIL rst_pre step%0d: got v=%b i=%0d c=%0d, exp v=1 i=%0d c=%0d",
                         i, valid, idx, cnt, exp_idx[i], i);
            end else n_pass++;
        end
        rst = 1'b1;
        tick();
        n_chk++;
        if ({valid, gnt, idx, cnt} !== {1'b0, 8'h00, 3'd0, 16'd0}) begin
            $display("FAIL rst_in_offer: got v=%b g=%h i=%0d c=%0d, exp v=0 g=00 i=0 c=0",
                     valid, gnt, idx, cnt);
        end else n_pass++;
        rst = 1'b0;
        tick();
        n_chk++;
        if ({valid, gnt, idx, cnt} !== {1'b1, 8'h80, 3'd7, 16'd0}) begin
            $display("FAIL rst_first_grant: got v=%b g=%h i=%0d c=%0d, exp v=1 g=80 i=7 c=0",
                     valid, gnt, idx, cnt);
        end else n_pass++;
        req   = 8'h00;
        ready = 1'b0;
    endtask

    task automatic test_wrap();
        apply_reset();
        req   = 8'hFF;
        ready = 1'b1;
        tick();
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i == 15) begin
                n_chk++;
                if ({cnt4, cnt} !== {4'd15, 16'd15}) begin
                    $display("FAIL wrap_15: got c4=%0d c16=%0d, exp c4=15 c16=15", cnt4, cnt);
                end else n_pass++;
            end
        end
        n_chk++;
        if ({valid4, cnt4, cnt} !== {1'b1, 4'd0, 16'd16}) begin
            $display("FAIL wrap_16: got v4=%b c4=%0d c16=%0d, exp v4=1 c4=0 c16=16", valid4, cnt4, cnt);
        end else n_pass++;
        req   = 8'h00;
        ready = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        req   = 8'h00;
        ready = 1'b0;
        test_reset();
        test_rr_pair();
        test_hold();
        test_single();
        test_back_to_back();
        test_reset_priority();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rr_lzc_scheduler.md
RR_LZC_SCHEDULER -- requirements
Module: rr_lzc_scheduler

Interface
REQ-001 Parameter NumReq, default 8, number of requesters (>=2, power of two not required).
REQ-002 Parameter CntWidth, default 16, width of the handshake counter.
REQ-003 clk_i  input  1  single clock; all state on rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 req_i  input  NumReq  per-requester request level.
REQ-006 ready_i  input  1  downstream accepts the offered grant.
REQ-007 valid_o  output  1  grant offered this cycle.
REQ-008 gnt_o  output  NumReq  one-hot grant, all-zero when valid_o=0.
REQ-009 gnt_idx_o  output  $clog2(NumReq)  index of granted requester, 0 when valid_o=0.
REQ-010 gnt_cnt_o  output  CntWidth  number of completed handshakes.

Function
REQ-011 FSM states IDLE and OFFER; valid_o SHALL be 1 exactly in OFFER.
REQ-012 Priority: the highest-index requesting bit wins, located by MSB-first leading-one detection; index = NumReq-1-first_one.
REQ-013 Round-robin: with last_idx the last handshaken index, the masked vector = req bits strictly below last_idx; if masked is non-empty it wins, else the unmasked vector wins.
REQ-014 IDLE -> OFFER on the cycle after any req_i bit is 1; gnt_o/gnt_idx_o registered from the arbitration of that cycle (1-cycle latency, request to valid_o).
REQ-015 In OFFER with ready_i=0: gnt_o, gnt_idx_o, valid_o SHALL stay stable, even if req_i changes, including the granted bit dropping.
REQ-016 Handshake = valid_o & ready_i: last_idx <= gnt_idx_o; gnt_cnt_o increments by 1.
REQ-017 On handshake, re-arbitrate the same cycle with the granted bit cleared from req_i and last_idx set to the current gnt_idx_o; non-empty -> stay in OFFER with the new grant next cycle (back-to-back, no bubble); empty -> IDLE.
REQ-018 ready_i in IDLE SHALL be ignored (no counter or pointer change).
REQ-019 gnt_cnt_o SHALL wrap modulo 2^CntWidth.
REQ-020 Only one requester is granted per handshake; no requester is granted twice while another requester holds req_i continuously (starvation bound: NumReq-1 handshakes).

Reset
REQ-021 rst_i=1 at a clock edge: state IDLE, valid_o=0, gnt_o=0, gnt_idx_o=0, gnt_cnt_o=0, last_idx=0; any pending offer is discarded.
REQ-022 Reset SHALL take priority over a simultaneous handshake; the first arbitration after reset uses the unmasked vector (last_idx=0 makes the mask empty).

Structure
REQ-023 A shared package SHALL hold the state enum (IDLE, OFFER) and the default NumReq/CntWidth constants.
REQ-024 Two instances of fp_leading_one (LEN=NumReq), one on the masked vector and one on the unmasked vector, SHALL perform the detection; no other sub-module.
REQ-025 The no_ones_o output of the masked instance selects masked vs unmasked; the no_ones_o output of the unmasked instance gates IDLE->OFFER.

Verification (NumReq=8)
REQ-026 Reset, req_i=8'h00 for 10 cycles -> valid_o=0, gnt_o=0, gnt_cnt_o=0 throughout.
REQ-027 req_i=8'h21 and ready_i=1 held -> grants idx 5, 0, 5, 0 on consecutive cycles after a 1-cycle latency; gnt_cnt_o increments every cycle.
REQ-028 req_i=8'h81, ready_i=0 for 5 cycles, req_i drops to 8'h01 -> gnt_o=8'h80 holds; on ready_i=1, next grant is idx 0 the following cycle.
REQ-029 Single req_i=8'h04 with ready_i=1 -> one handshake, then IDLE (valid_o=0) after the handshake cycle; gnt_cnt_o=1.
REQ-030 rst_i asserted in OFFER with ready_i=1 -> next cycle valid_o=0 and gnt_cnt_o=0; with req_i=8'hFF after reset released, first grant is idx 7.
REQ-031 CntWidth=4, 16 handshakes -> gnt_cnt_o wraps to 0.
